// File: rtl/tick_pipeline.sv
// EMA-crossover signal engine: fast/slow Q16.16 EMAs updated per accepted tick,
// BUY/SELL strobe when the fast EMA crosses the slow EMA, two-stage pipeline.
module tick_pipeline #(
  parameter int unsigned FAST_SHIFT = 3,
  parameter int unsigned SLOW_SHIFT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_price,
  output logic        out_valid,
  output logic [1:0]  out_signal,
  output logic [31:0] fast_dbg,
  output logic [31:0] slow_dbg
);

  typedef enum logic [1:0] {
    REL_EQUAL = 2'd0,
    REL_ABOVE = 2'd1,
    REL_BELOW = 2'd2
  } rel_t;

  localparam logic [1:0] SIG_HOLD = 2'b00;
  localparam logic [1:0] SIG_BUY  = 2'b01;
  localparam logic [1:0] SIG_SELL = 2'b11;

  logic [31:0] fast_ema;
  logic [31:0] slow_ema;
  logic [31:0] fast_next;
  logic [31:0] slow_next;
  logic        primed;
  logic        s1_valid;
  rel_t        s1_rel;
  rel_t        s1_prev_rel;
  rel_t        rel_next;
  logic [1:0]  signal_next;

  // Difference is taken at 33 bits so it cannot overflow; the arithmetic
  // shift floors toward -inf before truncating back to 32 bits.
  function automatic logic [31:0] ema_step(input logic [31:0] ema,
                                           input logic [31:0] price,
                                           input int unsigned shift);
    logic signed [32:0] d;
    logic signed [32:0] q;
    d = $signed({price[31], price}) - $signed({ema[31], ema});
    q = d >>> shift;
    return ema + q[31:0];
  endfunction

  always_comb begin
    fast_next = in_price;
    slow_next = in_price;
    if (primed) begin
      fast_next = ema_step(fast_ema, in_price, FAST_SHIFT);
      slow_next = ema_step(slow_ema, in_price, SLOW_SHIFT);
    end
    if ($signed(fast_next) > $signed(slow_next)) begin
      rel_next = REL_ABOVE;
    end else if ($signed(fast_next) < $signed(slow_next)) begin
      rel_next = REL_BELOW;
    end else begin
      rel_next = REL_EQUAL;
    end
  end

  // Stage 1: EMA state, relation of this sample and of the previous one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fast_ema    <= '0;
      slow_ema    <= '0;
      primed      <= 1'b0;
      s1_valid    <= 1'b0;
      s1_rel      <= REL_EQUAL;
      s1_prev_rel <= REL_EQUAL;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        fast_ema    <= fast_next;
        slow_ema    <= slow_next;
        primed      <= 1'b1;
        s1_prev_rel <= s1_rel;
        s1_rel      <= rel_next;
      end
    end
  end

  always_comb begin
    signal_next = SIG_HOLD;
    if (s1_rel == REL_ABOVE && s1_prev_rel != REL_ABOVE) begin
      signal_next = SIG_BUY;
    end else if (s1_rel == REL_BELOW && s1_prev_rel != REL_BELOW) begin
      signal_next = SIG_SELL;
    end
  end

  // Stage 2: output strobe; debug values hold across bubbles, signal drops to HOLD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_signal <= SIG_HOLD;
      fast_dbg   <= '0;
      slow_dbg   <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_signal <= signal_next;
        fast_dbg   <= fast_ema;
        slow_dbg   <= slow_ema;
      end else begin
        out_signal <= SIG_HOLD;
      end
    end
  end

endmodule

// File: tb/tb_tick_pipeline.sv
// Directed bench for tick_pipeline: each step drives one slot and checks the
// output strobe of the sample driven two steps earlier.
module tb_tick_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_price;
  logic        out_valid;
  logic [1:0]  out_signal;
  logic [31:0] fast_dbg;
  logic [31:0] slow_dbg;

  int checks   = 0;
  int failures = 0;
  int sell_seen = 0;

  // Pending expectations: index 0 = driven last step, index 1 = two steps ago.
  logic        pend_v [2];
  logic [1:0]  pend_s [2];
  logic [31:0] pend_f [2];
  logic [31:0] pend_sl[2];
  logic [31:0] last_f;
  logic [31:0] last_s;

  // Reference model state
  logic [31:0] m_fast;
  logic [31:0] m_slow;
  logic        m_primed;
  int          m_prev_rel;

  localparam logic [31:0] P100 = 32'd6553600;
  localparam logic [31:0] P110 = 32'd7208960;
  localparam logic [31:0] P90  = 32'd5898240;

  tick_pipeline #(.FAST_SHIFT(3), .SLOW_SHIFT(5)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_price(in_price),
    .out_valid(out_valid),
    .out_signal(out_signal),
    .fast_dbg(fast_dbg),
    .slow_dbg(slow_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_ema(input logic [31:0] e, input logic [31:0] p,
                                            input int sh);
    longint d;
    longint q;
    d = longint'($signed(p)) - longint'($signed(e));
    q = d >>> sh;
    return 32'(longint'($signed(e)) + q);
  endfunction

  task automatic step(input logic r, input logic v, input logic [31:0] p,
                      input logic hv, input logic [1:0] hs,
                      input logic [31:0] hf, input logic [31:0] hsl);
    int rel;
    logic [1:0] sig;
    @(negedge clk);
    checks++;
    assert (out_valid === pend_v[1]) else begin
      failures++;
      $error("FAIL out_valid observed=%0b expected=%0b t=%0t", out_valid, pend_v[1], $time);
    end
    if (pend_v[1]) begin
      checks++;
      assert (out_signal === pend_s[1]) else begin
        failures++;
        $error("FAIL signal observed=%0d expected=%0d t=%0t", out_signal, pend_s[1], $time);
      end
      checks++;
      assert (fast_dbg === pend_f[1]) else begin
        failures++;
        $error("FAIL fast_dbg observed=%0d expected=%0d t=%0t", fast_dbg, pend_f[1], $time);
      end
      checks++;
      assert (slow_dbg === pend_sl[1]) else begin
        failures++;
        $error("FAIL slow_dbg observed=%0d expected=%0d t=%0t", slow_dbg, pend_sl[1], $time);
      end
      last_f = pend_f[1];
      last_s = pend_sl[1];
    end else begin
      checks++;
      assert (out_signal === 2'b00) else begin
        failures++;
        $error("FAIL idle_signal observed=%0d expected=0 t=%0t", out_signal, $time);
      end
      checks++;
      assert (fast_dbg === last_f && slow_dbg === last_s) else begin
        failures++;
        $error("FAIL idle_dbg observed=%0d/%0d expected=%0d/%0d t=%0t",
               fast_dbg, slow_dbg, last_f, last_s, $time);
      end
    end
    if (out_valid === 1'b1 && out_signal === 2'b11) sell_seen++;

    pend_v[1]  = pend_v[0];
    pend_s[1]  = pend_s[0];
    pend_f[1]  = pend_f[0];
    pend_sl[1] = pend_sl[0];
    pend_v[0]  = 1'b0;
    pend_s[0]  = 2'b00;
    pend_f[0]  = '0;
    pend_sl[0] = '0;
    if (!r) begin
      pend_v[1]  = 1'b0;
      last_f     = '0;
      last_s     = '0;
      m_fast     = '0;
      m_slow     = '0;
      m_primed   = 1'b0;
      m_prev_rel = 0;
    end else if (v) begin
      if (!m_primed) begin
        m_fast = p;
        m_slow = p;
      end else begin
        m_fast = model_ema(m_fast, p, 3);
        m_slow = model_ema(m_slow, p, 5);
      end
      m_primed = 1'b1;
      rel = ($signed(m_fast) > $signed(m_slow)) ? 1 :
            ($signed(m_fast) < $signed(m_slow)) ? -1 : 0;
      sig = 2'b00;
      if (rel == 1 && m_prev_rel != 1) sig = 2'b01;
      if (rel == -1 && m_prev_rel != -1) sig = 2'b11;
      m_prev_rel = rel;
      pend_v[0]  = 1'b1;
      pend_s[0]  = hv ? hs  : sig;
      pend_f[0]  = hv ? hf  : m_fast;
      pend_sl[0] = hv ? hsl : m_slow;
    end
    rst      = r;
    in_valid = v;
    in_price = p;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_price = '0;
    for (int i = 0; i < 2; i++) begin
      pend_v[i] = 1'b0; pend_s[i] = 2'b00; pend_f[i] = '0; pend_sl[i] = '0;
    end
    last_f = '0; last_s = '0;
    m_fast = '0; m_slow = '0; m_primed = 1'b0; m_prev_rel = 0;

    // Reset held 5 cycles with in_valid toggling, then idle
    for (int i = 0; i < 5; i++) step(1'b0, 1'(i % 2), P110, 1'b0, 2'b00, '0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, 2'b00, '0, '0);

    // Constant price
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, P100, 1'b1, 2'b00, P100, P100);

    // Step-up crossover continuing from 100.0
    step(1'b1, 1'b1, P110, 1'b1, 2'b01, 32'd6635520, 32'd6574080);
    step(1'b1, 1'b1, P110, 1'b1, 2'b00, 32'd6707200, 32'd6593920);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, P110, 1'b0, 2'b00, '0, '0);

    // Step-down crossover: exactly one SELL
    step(1'b1, 1'b0, '0, 1'b0, 2'b00, '0, '0);
    step(1'b1, 1'b0, '0, 1'b0, 2'b00, '0, '0);
    sell_seen = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, P90, 1'b0, 2'b00, '0, '0);
    step(1'b1, 1'b0, '0, 1'b0, 2'b00, '0, '0);
    step(1'b1, 1'b0, '0, 1'b0, 2'b00, '0, '0);
    checks++;
    assert (sell_seen == 1) else begin
      failures++;
      $error("FAIL sell_count observed=%0d expected=1", sell_seen);
    end

    // Step-up stream with gaps of 1 and 3 cycles after a fresh reset
    step(1'b0, 1'b0, '0, 1'b0, 2'b00, '0, '0);
    step(1'b1, 1'b1, P100, 1'b1, 2'b00, P100, P100);
    step(1'b1, 1'b1, P110, 1'b1, 2'b01, 32'd6635520, 32'd6574080);
    step(1'b1, 1'b0, '0, 1'b0, 2'b00, '0, '0);
    step(1'b1, 1'b1, P110, 1'b1, 2'b00, 32'd6707200, 32'd6593920);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, 2'b00, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, P110, 1'b0, 2'b00, '0, '0);

    // Mid-stream reset with samples in flight, then re-prime
    step(1'b1, 1'b1, P110, 1'b0, 2'b00, '0, '0);
    step(1'b0, 1'b1, P110, 1'b0, 2'b00, '0, '0);
    step(1'b1, 1'b1, P110, 1'b1, 2'b00, P110, P110);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, 2'b00, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
